// File: rtl/text_write_ctrl.sv
// text_write_ctrl: turns received UART bytes into character-RAM writes.
// Tracks the text cursor, handles CR/LF/BS/FF, wraps and clears rows.
module text_write_ctrl #(
   parameter int COLS       = 80,
   parameter int ROWS       = 30,
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [6:0]        wr_data,
   output logic [6:0]        cur_x,
   output logic [4:0]        cur_y,
   output logic              busy,
   output logic              overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(ROWS*COLS-1);
   localparam logic [6:0]        X_MAX    = 7'(COLS-1);
   localparam logic [4:0]        Y_MAX    = 5'(ROWS-1);
   localparam logic [6:0]        SP       = 7'h20;

   typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;

   state_t            state_q, state_d;
   logic              rx_prev_q;
   logic [7:0]        fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              overflow_q, overflow_d;
   logic [6:0]        cur_x_q, cur_x_d;
   logic [4:0]        cur_y_q, cur_y_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [6:0]        wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [ADDR_W-1:0] clr_end_q, clr_end_d;
   logic              busy_q, busy_d;

   logic              push, pop, push_ok, do_nl;
   logic [7:0]        head;
   logic [4:0]        next_y;
   logic [ADDR_W-1:0] row_base, next_base;

   // Next-state logic: FIFO bookkeeping, byte decode and clear sequencing.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      cur_x_d    = cur_x_q;
      cur_y_d    = cur_y_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      clr_addr_d = clr_addr_q;
      clr_end_d  = clr_end_q;
      do_nl      = 1'b0;

      push    = rx_valid & ~rx_prev_q;
      pop     = (state_q == IDLE) && (cnt_q != '0);
      push_ok = push && ((cnt_q != CNT_FULL) || pop);
      head    = fifo_q[rd_ptr_q];

      row_base  = ADDR_W'(cur_y_q) * COLS_A;
      next_y    = (cur_y_q == Y_MAX) ? 5'd0 : cur_y_q + 5'd1;
      next_base = ADDR_W'(next_y) * COLS_A;

      if (push && !push_ok)
         overflow_d = 1'b1;
      if (push_ok)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase

      unique case (state_q)
         IDLE: begin
            if (pop) begin
               unique case (1'b1)
                  (head >= 8'h20 && head <= 8'h7E): begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = row_base + ADDR_W'(cur_x_q);
                     wr_data_d = head[6:0];
                     if (cur_x_q < X_MAX)
                        cur_x_d = cur_x_q + 7'd1;
                     else
                        do_nl = 1'b1;
                  end
                  (head == 8'h0D): cur_x_d = 7'd0;
                  (head == 8'h0A): do_nl = 1'b1;
                  (head == 8'h08): begin
                     if (cur_x_q != 7'd0) begin
                        cur_x_d   = cur_x_q - 7'd1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base
                                  + ADDR_W'(cur_x_q - 7'd1);
                        wr_data_d = SP;
                     end
                  end
                  (head == 8'h0C): begin
                     cur_x_d    = 7'd0;
                     cur_y_d    = 5'd0;
                     state_d    = CLR_ALL;
                     clr_addr_d = '0;
                     clr_end_d  = LAST_A;
                  end
                  default: ;
               endcase
               if (do_nl) begin
                  cur_x_d    = 7'd0;
                  cur_y_d    = next_y;
                  state_d    = CLR_ROW;
                  clr_addr_d = next_base;
                  clr_end_d  = next_base + COLS_A - ADDR_W'(1);
               end
            end
         end
         CLR_ROW, CLR_ALL: begin
            wr_en_d    = 1'b1;
            wr_addr_d  = clr_addr_q;
            wr_data_d  = SP;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == clr_end_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE) || (cnt_d != '0) || wr_en_d;
   end

   // State, cursor, FIFO pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rx_prev_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         cur_x_q    <= 7'd0;
         cur_y_q    <= 5'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 7'd0;
         clr_addr_q <= '0;
         clr_end_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_prev_q  <= rx_valid;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         cur_x_q    <= cur_x_d;
         cur_y_q    <= cur_y_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         clr_addr_q <= clr_addr_d;
         clr_end_q  <= clr_end_d;
         busy_q     <= busy_d;
      end
   end

   // FIFO storage; contents need no reset, pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && push_ok)
         fifo_q[wr_ptr_q] <= rx_data;
   end

   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign cur_x    = cur_x_q;
   assign cur_y    = cur_y_q;
   assign busy     = busy_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// tb_text_write_ctrl: scoreboard bench for text_write_ctrl.
// Stimulus queues expected writes; a monitor checks each wr_en cycle.
module tb_text_write_ctrl;

   localparam int COLS = 80;
   localparam int ROWS = 30;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [6:0]  wr_data;
   logic [6:0]  cur_x;
   logic [4:0]  cur_y;
   logic        busy;
   logic        overflow;

   int          checks = 0;
   int          fails = 0;
   logic [18:0] exp_q [$];
   int          mx = 0;
   int          my = 0;

   text_write_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_W(12), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_x(cur_x), .cur_y(cur_y),
      .busy(busy), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                     wr_addr, wr_data);
         end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               fails++;
               $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                        wr_addr, wr_data, e[18:7], e[6:0]);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push_w(input int addr, input int data);
      logic [11:0] a;
      logic [6:0]  d;
      a = 12'(addr);
      d = 7'(data);
      exp_q.push_back({a, d});
   endtask

   task automatic model_nl();
      mx = 0;
      my = (my == ROWS-1) ? 0 : my + 1;
      for (int k = 0; k < COLS; k++)
         push_w(my*COLS + k, 8'h20);
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         push_w(my*COLS + mx, int'(b[6:0]));
         if (mx < COLS-1) mx++;
         else model_nl();
      end else if (b == 8'h0D) begin
         mx = 0;
      end else if (b == 8'h0A) begin
         model_nl();
      end else if (b == 8'h08) begin
         if (mx > 0) begin
            mx--;
            push_w(my*COLS + mx, 8'h20);
         end
      end else if (b == 8'h0C) begin
         mx = 0;
         my = 0;
         for (int k = 0; k < ROWS*COLS; k++)
            push_w(k, 8'h20);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit expect_it);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      if (expect_it) model_byte(b);
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) check("idle_timeout", 1, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      mx = 0;
      my = 0;
   endtask

   task automatic check_cur(input string name, input int x, input int y);
      check({name, "_x"}, int'(cur_x), x);
      check({name, "_y"}, int'(cur_y), y);
   endtask

   initial begin
      int w, bad, n;
      // 1: reset state and quiet idle
      do_reset();
      check("rst_wr_en", int'(wr_en), 0);
      check("rst_wr_addr", int'(wr_addr), 0);
      check("rst_wr_data", int'(wr_data), 0);
      check_cur("rst_cur", 0, 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overflow", int'(overflow), 0);
      w = 0;
      repeat (20) begin
         @(negedge clk);
         if (wr_en) w++;
      end
      check("idle_no_write", w, 0);

      // 2: single byte, long rx_valid, 2-cycle latency
      @(negedge clk);
      rx_data  = 8'h41;
      rx_valid = 1'b1;
      model_byte(8'h41);
      @(posedge clk);
      #1 check("lat_edge_n", int'(wr_en), 0);
      @(posedge clk);
      #1 check("lat_edge_n1", int'(wr_en), 1);
      repeat (3) @(negedge clk);
      rx_valid = 1'b0;
      wait_idle();
      check_cur("one_byte", 1, 0);

      // 3: full row of printables wraps and clears row 1
      send(8'h0D, 1'b1);
      wait_idle();
      check_cur("cr", 0, 0);
      for (int i = 0; i < COLS; i++)
         send(8'(8'h30 + (i % 8'h4F)), 1'b1);
      wait_idle();
      check_cur("wrap", 0, 1);

      // 4: backspace handling and ignored codes
      do_reset();
      send(8'h41, 1'b1);
      send(8'h42, 1'b1);
      send(8'h08, 1'b1);
      wait_idle();
      check_cur("bs1", 1, 0);
      send(8'h08, 1'b1);
      send(8'h08, 1'b1);
      wait_idle();
      check_cur("bs0", 0, 0);
      send(8'h85, 1'b1);
      send(8'h01, 1'b1);
      wait_idle();
      check_cur("ignored", 0, 0);

      // 5: form feed clears the whole screen back to back
      send(8'h0C, 1'b1);
      n = 0;
      while (!wr_en && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ff_start", int'(wr_en), 1);
      bad = 0;
      for (int i = 0; i < ROWS*COLS; i++) begin
         if (!(wr_en && busy)) bad++;
         @(negedge clk);
      end
      check("ff_consecutive_busy", bad, 0);
      check("ff_done_wr_en", int'(wr_en), 0);
      check("ff_done_busy", int'(busy), 0);
      check_cur("ff", 0, 0);

      // 6: walk to bottom row, LF wraps to top, overflow
      for (int i = 0; i < ROWS-1; i++) begin
         send(8'h0A, 1'b1);
         wait_idle();
      end
      check_cur("lf29", 0, 29);
      for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 1'b1);
      wait_idle();
      check_cur("pos5", 5, 29);
      send(8'h0D, 1'b1);
      wait_idle();
      check_cur("cr29", 0, 29);
      for (int i = 0; i < 5; i++) send(8'(8'h35 + i), 1'b1);
      wait_idle();
      check_cur("pos5b", 5, 29);
      check("ovf_before", int'(overflow), 0);
      send(8'h0A, 1'b1);
      for (int i = 0; i < 4; i++) send(8'(8'h61 + i), 1'b1);
      send(8'h65, 1'b0);
      check("ovf_set", int'(overflow), 1);
      check("busy_in_clr", int'(busy), 1);
      check_cur("cur_in_clr", 0, 0);
      wait_idle();
      check_cur("after_ovf", 4, 0);
      check("ovf_sticky", int'(overflow), 1);
      repeat (5) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/text_write_ctrl.md
Name: text_write_ctrl

Overview:
Downstream consumer of the inter-board UART receive path. Takes received ASCII bytes (data byte plus received strobe) and turns them into character-RAM writes for the VGA text screen generator. Maintains the text cursor and handles CR/LF/backspace/form-feed, auto-wrap and row clearing. A small input FIFO absorbs bytes that arrive while a multi-cycle clear is running.

Parameters:
COLS, 80, characters per row
ROWS, 30, text rows per screen
ADDR_W, 12, character RAM address width; must satisfy ROWS*COLS <= 2^ADDR_W
FIFO_DEPTH, 4, input byte FIFO entries; power of 2

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte from UART; valid while rx_valid is high
rx_valid  input  1  UART received flag; may be high for multiple cycles; one byte per rising edge
wr_en  output  1  character RAM write strobe, one cycle per write
wr_addr  output  ADDR_W  write address = row*COLS + col
wr_data  output  7  ASCII code written (rx_data[6:0] or 0x20)
cur_x  output  7  cursor column, 0..COLS-1
cur_y  output  5  cursor row, 0..ROWS-1
busy  output  1  high when state != IDLE or FIFO non-empty
overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, highest priority, aborts any operation): wr_en=0, wr_addr=0, wr_data=0, cur_x=0, cur_y=0, busy=0, overflow=0, FIFO emptied, state=IDLE, rx_valid edge register=0. Screen contents are not cleared by reset.
- Input capture: rx_valid is registered once. A push occurs in the cycle where rx_valid=1 and the registered copy=0; rx_data is sampled in that same cycle.
- Push when FIFO full: the byte is dropped and overflow is set (held until reset). Exception: if a pop happens in the same cycle, the push is accepted.
- Pops happen only in IDLE, at most one per cycle.
- Latency: with FIFO empty and state IDLE, the rising edge of rx_valid is sampled at clock edge N. For a printable byte, wr_en is high in the cycle following edge N+1 (2 cycles of latency).
- All outputs are registered.
- States: IDLE, CLR_ROW, CLR_ALL.
- IDLE, FIFO non-empty: pop one byte b and decode it.
  - 0x20..0x7E (printable): write b[6:0] at (cur_y, cur_x).
    - If cur_x < COLS-1: cur_x+1.
    - Otherwise: newline.
  - 0x0D (CR): cur_x=0. No write.
  - 0x0A (LF): newline.
  - 0x08 (BS), cur_x > 0: cur_x-1, then write 0x20 at the new position.
  - 0x08 (BS), cur_x = 0: no-op. No reverse wrap.
  - 0x0C (FF): cur_x=0, cur_y=0, enter CLR_ALL.
  - Any other value, including b[7]=1: consumed and ignored. No write, no cursor change.
- Newline:
  - cur_x=0.
  - cur_y = cur_y+1, or 0 if cur_y = ROWS-1.
  - Enter CLR_ROW for the new cur_y.
  - A printable write that triggers a newline completes in its own cycle; CLR_ROW starts the next cycle.
- CLR_ROW: COLS consecutive cycles of wr_en=1, wr_data=0x20, addresses cur_y*COLS .. cur_y*COLS+COLS-1 ascending. Then return to IDLE.
- CLR_ALL: ROWS*COLS consecutive cycles of wr_en=1, wr_data=0x20, addresses 0 .. ROWS*COLS-1. Then return to IDLE.
- During a clear: the FIFO continues accepting pushes, no pops occur, and the cursor is stable.
- wr_en is 0 in every cycle without a write. wr_addr and wr_data hold their last values when wr_en=0.
- Address arithmetic: width ADDR_W, no truncation for the default parameters (max 2399).

Test Plan:
1. Hold reset 3 cycles, release -> all outputs 0, busy=0, no wr_en for 20 idle cycles.
2. rx_data=0x41, rx_valid high for 5 cycles -> exactly one wr_en, 2 cycles after the sampled rising edge, addr 0, data 0x41; then cur_x=1, cur_y=0.
3. 80 printable bytes 0x30.. -> the 80th byte is written at addr 79; then 80 consecutive writes of 0x20 at addr 80..159; then cur_x=0, cur_y=1.
4. Send 'A','B',0x08 -> writes 0x41@0, 0x42@1, 0x20@1; cur_x=1. A further 0x08,0x08 -> 0x20@0, then no write; cur_x=0.
5. 0x0C -> 2400 consecutive writes of 0x20, addr 0..2399; busy high throughout; cursor (0,0); busy=0 afterwards.
6. Cursor at (5,29), send 0x0A -> cur=(0,0) and 80 writes of 0x20 at addr 0..79. During that clear, send 5 bytes -> first 4 queued, overflow=1, and the 4 bytes are processed after the clear.
